// File: rtl/acc_pkg.sv
// Shared accelerator package: bus widths, writeback FSM encoding and the
// 16-bit saturation helper used by the result writeback stage.
package acc_pkg;

    localparam int unsigned ACC_DATA_W         = 32;
    localparam int unsigned ACC_ADDR_W         = 13;
    localparam int unsigned OFMAP_BASE_DEFAULT = 6144;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } wb_state_e;

    // Clamp a signed 32-bit value into the signed 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7fff;
        end else if (x < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[15:0];
        end
    endfunction

endpackage

// File: rtl/ofmap_writeback_if.sv
// Result-stream and SRAM write-port bundle for the ofmap writeback stage.
//   din/din_valid  : convolution result stream into the writeback stage
//   sram_wr_ready  : write grant from the SRAM arbiter
//   sram_we/waddr/wdata : SRAM write port driven by the writeback stage
// master = writeback stage (drives the SRAM write port),
// slave  = surrounding fabric (drives results and the grant).
interface ofmap_writeback_if #(
    parameter int unsigned DATA_W = acc_pkg::ACC_DATA_W,
    parameter int unsigned ADDR_W = acc_pkg::ACC_ADDR_W
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              sram_wr_ready;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_waddr;
    logic [DATA_W-1:0] sram_wdata;

    modport master (
        input  din, din_valid, sram_wr_ready,
        output sram_we, sram_waddr, sram_wdata
    );

    modport slave (
        output din, din_valid, sram_wr_ready,
        input  sram_we, sram_waddr, sram_wdata
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; head always presents the oldest entry.
//   push/wdata : enqueue (accepted when not full, or when popping while full)
//   pop        : dequeue the head (ignored when empty)
//   head       : oldest entry, valid while !empty
//   full/empty : occupancy flags
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   cnt;
    logic             wr_en;
    logic             rd_en;

    // A push into a full FIFO still lands when the head leaves the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign full  = (cnt == (PTR_W+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = mem[rptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PTR_W'(1);
            if (rd_en) rptr <= rptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are qualified by empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/ofmap_writeback.sv
// Ofmap writeback: requantises convolution results (shift, optional ReLU,
// 16-bit saturation), packs two per word and writes them to SRAM.
//   clk, rst        : clock, synchronous active-high reset
//   start, cfg_*    : job launch and configuration (latched in IDLE)
//   bus             : result stream in, SRAM write port out
//   busy, done      : job in progress / one-cycle completion pulse
//   overflow        : sticky, a packed word was dropped on a full FIFO
//   words_written   : words committed to SRAM in the current job
module ofmap_writeback
    import acc_pkg::*;
#(
    parameter int unsigned DATA_W     = ACC_DATA_W,
    parameter int unsigned ADDR_W     = ACC_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  cfg_base,
    input  logic [ADDR_W-1:0]  cfg_count,
    input  logic [4:0]         cfg_shift,
    input  logic               cfg_relu,
    ofmap_writeback_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [ADDR_W-1:0]  words_written
);
    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_RUN   = 2'(RUN);
    localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
    localparam logic [1:0] ST_FIN   = 2'(FIN);

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [ADDR_W-1:0]  count_q;
    logic [4:0]         shift_q;
    logic               relu_q;
    logic [ADDR_W-1:0]  in_cnt;
    logic [ADDR_W-1:0]  waddr_q;
    logic               proc_valid;
    logic [15:0]        proc_data;
    logic               proc_odd;
    logic               proc_last;
    logic [15:0]        pack_lo;

    logic                     accept_c;
    logic                     last_in_c;
    logic signed [DATA_W-1:0] shifted;
    logic signed [DATA_W-1:0] clamped;
    logic [15:0]              proc_next;
    logic                     push_c;
    logic [DATA_W-1:0]        push_data;
    logic                     pop_c;
    logic [DATA_W-1:0]        fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;

    // Input acceptance and requantisation of the incoming result.
    assign accept_c  = (state == ST_RUN) && bus.din_valid && (in_cnt != count_q);
    assign last_in_c = (in_cnt == count_q - ADDR_W'(1));
    assign shifted   = $signed(bus.din) >>> shift_q;
    assign clamped   = (relu_q && shifted[DATA_W-1]) ? '0 : shifted;
    assign proc_next = sat16(32'(clamped));

    // Odd results complete a word; a trailing even result goes out alone.
    assign push_c    = proc_valid && (proc_odd || proc_last);
    assign push_data = proc_odd ? DATA_W'({proc_data, pack_lo})
                                : DATA_W'({16'h0000, proc_data});

    // Reset gates the strobe so no write escapes in the reset cycle.
    assign pop_c          = !fifo_empty && bus.sram_wr_ready && !rst;
    assign bus.sram_we    = pop_c;
    assign bus.sram_waddr = waddr_q;
    assign bus.sram_wdata = fifo_empty ? '0 : fifo_head;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .wdata (push_data),
        .pop   (pop_c),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = (cfg_count == '0) ? ST_FIN : ST_RUN;
            ST_RUN:   if (accept_c && last_in_c) next_state = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && !proc_valid) next_state = ST_FIN;
            ST_FIN:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // State, datapath and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            words_written <= '0;
            count_q       <= '0;
            shift_q       <= '0;
            relu_q        <= 1'b0;
            in_cnt        <= '0;
            waddr_q       <= '0;
            proc_valid    <= 1'b0;
            proc_data     <= '0;
            proc_odd      <= 1'b0;
            proc_last     <= 1'b0;
            pack_lo       <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state == ST_RUN) || (next_state == ST_DRAIN);
            done  <= (next_state == ST_FIN);

            if (state == ST_IDLE && start) begin
                count_q       <= cfg_count;
                shift_q       <= cfg_shift;
                relu_q        <= cfg_relu;
                waddr_q       <= cfg_base;
                in_cnt        <= '0;
                words_written <= '0;
                overflow      <= 1'b0;
            end

            if (accept_c) begin
                in_cnt    <= in_cnt + ADDR_W'(1);
                proc_data <= proc_next;
                proc_odd  <= in_cnt[0];
                proc_last <= last_in_c;
            end
            proc_valid <= accept_c;

            if (proc_valid && !proc_odd) pack_lo <= proc_data;

            // Dropped word still counts toward completion via in_cnt.
            if (push_c && fifo_full && !pop_c) overflow <= 1'b1;

            if (pop_c) begin
                waddr_q       <= waddr_q + ADDR_W'(1);
                words_written <= words_written + ADDR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ofmap_writeback.sv
// Directed bench for ofmap_writeback: table of jobs plus hand-written
// sequences for zero count, back-pressure/overflow and reset mid-job.
module tb_ofmap_writeback;
    import acc_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 13;

    typedef struct {
        logic [AW-1:0]     base;
        logic [AW-1:0]     count;
        logic [4:0]        shift;
        logic              relu;
        logic [3:0][31:0]  din;
        int                nw;
        logic [1:0][AW-1:0] addr;
        logic [1:0][31:0]  word;
        bit                extra;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] cfg_base;
    logic [AW-1:0] cfg_count;
    logic [4:0]    cfg_shift;
    logic          cfg_relu;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW-1:0] words_written;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [AW-1:0] wa_q [$];
    logic [31:0]   wd_q [$];
    vec_t vecs [10];

    always #5 clk = ~clk;

    ofmap_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ofmap_writeback #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_base      (cfg_base),
        .cfg_count     (cfg_count),
        .cfg_shift     (cfg_shift),
        .cfg_relu      (cfg_relu),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .words_written (words_written)
    );

    // Capture SRAM writes and done pulses away from the active edge.
    always @(negedge clk) begin
        if (bus.sram_we) begin
            wa_q.push_back(bus.sram_waddr);
            wd_q.push_back(bus.sram_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int base, input int count, input int shift, input bit relu,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input int nw, input int a0, input logic [31:0] w0,
                                input int a1, input logic [31:0] w1, input bit extra);
        vec_t v;
        v.base = AW'(base);  v.count = AW'(count); v.shift = 5'(shift); v.relu = relu;
        v.din[0] = d0; v.din[1] = d1; v.din[2] = d2; v.din[3] = d3;
        v.nw = nw;
        v.addr[0] = AW'(a0); v.word[0] = w0;
        v.addr[1] = AW'(a1); v.word[1] = w1;
        v.extra = extra;
        return v;
    endfunction

    task automatic launch(input logic [AW-1:0] base, input logic [AW-1:0] count,
                          input logic [4:0] shift, input logic relu);
        @(posedge clk); #1;
        start = 1'b1; cfg_base = base; cfg_count = count; cfg_shift = shift; cfg_relu = relu;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d);
        bus.din = d; bus.din_valid = 1'b1;
        @(posedge clk); #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done) break;
        end
        check({nm, " done_timeout"}, 32'(n < 300), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int w0;
        int d0;
        string nm;
        v  = vecs[k];
        w0 = wa_q.size();
        d0 = done_cnt;
        nm = $sformatf("vec%0d", k);
        launch(v.base, v.count, v.shift, v.relu);
        for (int i = 0; i < int'(v.count); i++) begin
            bus.din = v.din[i]; bus.din_valid = 1'b1;
            if (v.extra && i == 1) begin
                start = 1'b1; cfg_base = '0; cfg_count = AW'(1);
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (v.extra) begin
            bus.din = 32'h0000dead; bus.din_valid = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end
        bus.din_valid = 1'b0;
        wait_done(nm);
        check({nm, " nwrites"}, 32'(wa_q.size() - w0), 32'(v.nw));
        for (int i = 0; i < v.nw; i++) begin
            if (w0 + i < wa_q.size()) begin
                check($sformatf("%s addr%0d", nm, i), 32'(wa_q[w0+i]), 32'(v.addr[i]));
                check($sformatf("%s data%0d", nm, i), wd_q[w0+i], v.word[i]);
            end
        end
        check({nm, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({nm, " words_written"}, 32'(words_written), 32'(v.nw));
        check({nm, " busy_after"}, 32'(busy), 32'd0);
        check({nm, " overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int w0;
        int d0;

        vecs[0] = mk(6144, 4, 0, 0, 32'd1, 32'd2, 32'd3, 32'd4,
                     2, 6144, 32'h00020001, 6145, 32'h00040003, 0);
        vecs[1] = mk(100, 2, 4, 0, 32'h00100000, 32'hFFFFFFA0, 0, 0,
                     1, 100, 32'hFFFA7FFF, 0, 0, 0);
        vecs[2] = mk(100, 2, 4, 1, 32'h00100000, 32'hFFFFFF9C, 0, 0,
                     1, 100, 32'h00007FFF, 0, 0, 0);
        vecs[3] = mk(200, 3, 0, 0, 32'd5, 32'd6, 32'd7, 0,
                     2, 200, 32'h00060005, 201, 32'h00000007, 0);
        vecs[4] = mk(8191, 4, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44,
                     2, 8191, 32'h00220011, 0, 32'h00440033, 1);
        vecs[5] = mk(300, 2, 0, 0, 32'hFFFFFF9C, 32'h80000000, 0, 0,
                     1, 300, 32'h8000FF9C, 0, 0, 0);
        vecs[6] = mk(301, 2, 31, 0, 32'h80000000, 32'd5, 0, 0,
                     1, 301, 32'h0000FFFF, 0, 0, 0);
        vecs[7] = mk(400, 2, 1, 0, 32'hFFFFFF9C, 32'h0000FFFE, 0, 0,
                     1, 400, 32'h7FFFFFCE, 0, 0, 0);
        vecs[8] = mk(500, 1, 0, 1, 32'hFFFFFFFF, 0, 0, 0,
                     1, 500, 32'h00000000, 0, 0, 0);
        vecs[9] = mk(600, 2, 4, 0, 32'hFFFFFF9C, 32'h00000010, 0, 0,
                     1, 600, 32'h0001FFF9, 0, 0, 0);

        rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_count = '0; cfg_shift = '0; cfg_relu = 1'b0;
        bus.din = '0; bus.din_valid = 1'b0; bus.sram_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst sram_we", 32'(bus.sram_we), 32'd0);
        check("rst words_written", 32'(words_written), 32'd0);
        check("rst sram_waddr", 32'(bus.sram_waddr), 32'd0);
        check("rst sram_wdata", bus.sram_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int k = 0; k < 10; k++) run_vec(k);

        // Zero-length job: straight to FIN, no writes.
        w0 = wa_q.size(); d0 = done_cnt;
        launch(13'd10, 13'd0, 5'd0, 1'b0);
        wait_done("zero");
        check("zero nwrites", 32'(wa_q.size() - w0), 32'd0);
        check("zero done_pulses", 32'(done_cnt - d0), 32'd1);

        // Back-pressure: 10 words into an 8-deep FIFO with the grant low.
        bus.sram_wr_ready = 1'b0;
        w0 = wa_q.size(); d0 = done_cnt;
        launch(13'd0, 13'd20, 5'd0, 1'b0);
        for (int i = 1; i <= 16; i++) feed(32'(i));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp overflow_at_full", 32'(overflow), 32'd0);
        check("bp busy", 32'(busy), 32'd1);
        check("bp no_writes", 32'(wa_q.size() - w0), 32'd0);
        @(posedge clk); #1;
        for (int i = 17; i <= 20; i++) feed(32'(i));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp overflow_set", 32'(overflow), 32'd1);
        @(posedge clk); #1;
        bus.sram_wr_ready = 1'b1;
        wait_done("bp");
        check("bp nwrites", 32'(wa_q.size() - w0), 32'd8);
        for (int j = 0; j < 8; j++) begin
            if (w0 + j < wa_q.size()) begin
                check($sformatf("bp addr%0d", j), 32'(wa_q[w0+j]), 32'(j));
                check($sformatf("bp data%0d", j), wd_q[w0+j], {16'(2*j+2), 16'(2*j+1)});
            end
        end
        check("bp words_written", 32'(words_written), 32'd8);
        check("bp overflow_sticky", 32'(overflow), 32'd1);
        check("bp done_pulses", 32'(done_cnt - d0), 32'd1);

        // Reset mid-job after a single word has been written.
        bus.sram_wr_ready = 1'b0;
        w0 = wa_q.size();
        launch(13'd50, 13'd20, 5'd0, 1'b0);
        for (int i = 1; i <= 20; i++) feed(32'(i));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid overflow_pre", 32'(overflow), 32'd1);
        @(posedge clk); #1;
        bus.sram_wr_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid we_in_reset", 32'(bus.sram_we), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid busy", 32'(busy), 32'd0);
        check("mid sram_we", 32'(bus.sram_we), 32'd0);
        check("mid overflow", 32'(overflow), 32'd0);
        check("mid words_written", 32'(words_written), 32'd0);
        repeat (6) @(negedge clk);
        check("mid nwrites", 32'(wa_q.size() - w0), 32'd1);
        if (wa_q.size() > w0) begin
            check("mid addr", 32'(wa_q[w0]), 32'd50);
            check("mid data", wd_q[w0], 32'h00020001);
        end

        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
